// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: RX FSM states,
// 8N1 framing constants and the little-endian byte-lane mapping.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 8;

    // Byte index 0 lands in bits [7:0], index 3 in bits [31:24].
    function automatic int lane_lsb(input logic [1:0] idx);
        return int'(idx) * LANE_W;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream from the UART receiver to the word assembler.
// Handshake: byte_valid and frame_err are one-cycle strobes with no ready;
// the consumer must take byte_data in the cycle byte_valid is high.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic                 byte_valid;
    logic [DATA_BITS-1:0] byte_data;
    logic                 frame_err;
    rx_state_e            state;

    modport master (output byte_valid, output byte_data, output frame_err, output state);
    modport slave  (input  byte_valid, input  byte_data, input  frame_err, input  state);

endinterface

// File: rtl/imem_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid on a good stop bit and one-cycle frame_err on a bad one.
module uart_rx_byte
    import imem_loader_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rx_i,
    input  logic          en_i,
    imem_loader_if.master byte_o
);

    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic                 sync1_q, sync2_q, prev_q;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
            prev_q  <= IDLE_LEVEL;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (en_i && prev_q && (sync2_q == START_LEVEL)) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A line that is high again at mid-start is a glitch, not a frame.
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = (sync2_q == START_LEVEL) ? RX_DATA : RX_IDLE;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync2_q == STOP_LEVEL) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o.byte_valid = valid_q;
    assign byte_o.byte_data  = shift_q;
    assign byte_o.frame_err  = ferr_q;
    assign byte_o.state      = state_q;

endmodule

// File: rtl/imem_loader.sv
// Loads 32-bit instruction words received over UART into instruction memory,
// little-endian, at consecutive word addresses while load_en is high.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              uart_rx,
    input  logic              load_en,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    imem_loader_if rxb ();

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clk    (clk),
        .rstn   (rstn),
        .rx_i   (uart_rx),
        .en_i   (load_en),
        .byte_o (rxb)
    );

    logic              load_q;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              load_rise, load_fall;

    assign load_rise = load_en & ~load_q;
    assign load_fall = ~load_en & load_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_q  <= 1'b0;
            idx_q   <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            load_q  <= load_en;
            idx_q   <= idx_d;
            word_q  <= word_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        idx_d   = idx_q;
        word_d  = word_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        ferr_d  = ferr_q;
        // A new load session wins over anything arriving in the same cycle.
        if (load_rise) begin
            idx_d  = '0;
            word_d = '0;
            cnt_d  = '0;
            done_d = 1'b0;
            ferr_d = 1'b0;
        end else begin
            if (load_fall) begin
                idx_d  = '0;
                word_d = '0;
            end
            if (rxb.frame_err) begin
                ferr_d = 1'b1;
            end
            if (rxb.byte_valid && load_en) begin
                word_d[lane_lsb(idx_q) +: LANE_W] = rxb.byte_data;
                if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
                    idx_d = '0;
                    // Once memory is full, words are still framed but dropped.
                    if (!done_q) begin
                        we_d    = 1'b1;
                        waddr_d = cnt_q[ADDR_W-1:0];
                        wdata_d = word_d;
                        cnt_d   = cnt_q + (ADDR_W + 1)'(1);
                        done_d  = (cnt_d == FULL);
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
        end
    end

    assign we_o        = we_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;
    assign cpu_hold_o  = load_q;
    assign busy_o      = (rxb.state != RX_IDLE);
    assign done_o      = done_q;
    assign frame_err_o = ferr_q;
    assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: UART frames driven bit by bit at DIV=10,
// memory writes checked against an expected address/data queue.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIV    = 10;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              uart_rx = 1'b1;
  logic              load_en = 1'b0;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [31:0]       wdata_o;
  logic              cpu_hold_o;
  logic              busy_o;
  logic              done_o;
  logic              frame_err_o;
  logic [ADDR_W:0]   word_cnt_o;

  int checks = 0;
  int failures = 0;
  int we_seen = 0;
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  imem_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .uart_rx     (uart_rx),
    .load_en     (load_en),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .cpu_hold_o  (cpu_hold_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .frame_err_o (frame_err_o),
    .word_cnt_o  (word_cnt_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (we_o === 1'b1) begin
      we_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {31'b0, we_o}, 32'd0);
      end else begin
        chk("we_addr", {26'b0, waddr_o}, {26'b0, exp_addr_q.pop_front()});
        chk("we_data", wdata_o, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop_b;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic toggle_load();
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    load_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string ph);
    chk({ph, "_we"},       {31'b0, we_o}, 32'd0);
    chk({ph, "_waddr"},    {26'b0, waddr_o}, 32'd0);
    chk({ph, "_wdata"},    wdata_o, 32'd0);
    chk({ph, "_busy"},     {31'b0, busy_o}, 32'd0);
    chk({ph, "_done"},     {31'b0, done_o}, 32'd0);
    chk({ph, "_ferr"},     {31'b0, frame_err_o}, 32'd0);
    chk({ph, "_word_cnt"}, {25'b0, word_cnt_o}, 32'd0);
    chk({ph, "_hold"},     {31'b0, cpu_hold_o}, 32'd0);
  endtask

  function automatic logic [31:0] word_of(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {8'hA5, kb, ~kb, kb ^ 8'h3C};
  endfunction

  initial begin
    int n;
    logic [7:0] part;

    // reset state
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rstn = 1'b1;
    @(negedge clk);
    load_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("hold_on", {31'b0, cpu_hold_o}, 32'd1);

    // first word: addi x1,x0,5
    expect_write(6'd0, 32'h00500093);
    send_byte(8'h93, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h50, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("w1_we_count", we_seen, 32'd1);
    chk("w1_waddr", {26'b0, waddr_o}, 32'd0);
    chk("w1_wdata", wdata_o, 32'h00500093);
    chk("w1_word_cnt", {25'b0, word_cnt_o}, 32'd1);
    chk("w1_ferr", {31'b0, frame_err_o}, 32'd0);

    // 3-cycle glitch on the line
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    chk("glitch_busy_rose", {31'b0, busy_o}, 32'd1);
    n = 0;
    while (busy_o && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("glitch_busy_idle", {31'b0, busy_o}, 32'd0);
    repeat (15) @(negedge clk);
    chk("glitch_ferr", {31'b0, frame_err_o}, 32'd0);
    chk("glitch_no_we", we_seen, 32'd1);
    chk("glitch_word_cnt", {25'b0, word_cnt_o}, 32'd1);

    // bad stop bit, then a good word
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_off", {31'b0, cpu_hold_o}, 32'd0);
    load_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reload_word_cnt", {25'b0, word_cnt_o}, 32'd0);
    send_byte(8'h13, 1'b0);
    repeat (2) @(negedge clk);
    chk("ferr_set", {31'b0, frame_err_o}, 32'd1);
    chk("ferr_no_we", we_seen, 32'd1);
    expect_write(6'd0, 32'h04030201);
    send_word(32'h04030201);
    chk("ferr_next_we_count", we_seen, 32'd2);
    chk("ferr_next_word_cnt", {25'b0, word_cnt_o}, 32'd1);
    chk("ferr_sticky", {31'b0, frame_err_o}, 32'd1);

    // fill all 64 words, then one extra
    toggle_load();
    chk("fill_ferr_cleared", {31'b0, frame_err_o}, 32'd0);
    chk("fill_cnt_cleared", {25'b0, word_cnt_o}, 32'd0);
    chk("fill_done_clear", {31'b0, done_o}, 32'd0);
    for (int k = 0; k < 64; k++) begin
      expect_write(6'(k), word_of(k));
      send_word(word_of(k));
      if (k == 62) chk("fill_done_before_last", {31'b0, done_o}, 32'd0);
    end
    chk("fill_done", {31'b0, done_o}, 32'd1);
    chk("fill_word_cnt", {25'b0, word_cnt_o}, 32'd64);
    chk("fill_we_count", we_seen, 32'd66);
    chk("fill_queue_empty", exp_q.size(), 32'd0);
    send_word(32'hDEADBEEF);
    chk("extra_no_we", we_seen, 32'd66);
    chk("extra_done", {31'b0, done_o}, 32'd1);
    chk("extra_word_cnt", {25'b0, word_cnt_o}, 32'd64);
    chk("extra_waddr", {26'b0, waddr_o}, 32'd63);
    chk("extra_wdata", wdata_o, word_of(63));

    // load_en dropped after two bytes discards the partial word
    toggle_load();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    toggle_load();
    expect_write(6'd0, 32'h0000006F);
    send_byte(8'h6F, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("toggle_we_count", we_seen, 32'd67);
    chk("toggle_waddr", {26'b0, waddr_o}, 32'd0);
    chk("toggle_wdata", wdata_o, 32'h0000006F);
    chk("toggle_word_cnt", {25'b0, word_cnt_o}, 32'd1);

    // reset during data bit 4
    part = 8'h5A;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = part[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = part[4];
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("midrst");
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_we", we_seen, 32'd67);
    chk("midrst_hold", {31'b0, cpu_hold_o}, 32'd1);
    expect_write(6'd0, 32'h11223344);
    send_word(32'h11223344);
    chk("post_rst_we_count", we_seen, 32'd68);
    chk("post_rst_waddr", {26'b0, waddr_o}, 32'd0);
    chk("post_rst_wdata", wdata_o, 32'h11223344);
    chk("post_rst_word_cnt", {25'b0, word_cnt_o}, 32'd1);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the UART bit rate.
REQ-003 The block SHALL have parameter ADDR_W, default 6, meaning the instruction-memory word-address width (64 words).
REQ-004 The block SHALL have port clk, input, 1, system clock.
REQ-005 The block SHALL have port rstn, input, 1, reset; rstn is asynchronous and active-low, and the clock is clk.
REQ-006 The block SHALL have port uart_rx, input, 1, asynchronous serial line (8N1, idle high).
REQ-007 The block SHALL have port load_en, input, 1, load-mode switch.
REQ-008 The block SHALL have port we_o, output, 1, one-cycle instruction-memory write strobe.
REQ-009 The block SHALL have port waddr_o, output, ADDR_W, word write address.
REQ-010 The block SHALL have port wdata_o, output, 32, instruction word to write.
REQ-011 The block SHALL have port cpu_hold_o, output, 1, holds the CPU PC at 0 while high.
REQ-012 The block SHALL have port busy_o, output, 1, high while a UART frame is in progress.
REQ-013 The block SHALL have port done_o, output, 1, sticky indicator that memory is full.
REQ-014 The block SHALL have port frame_err_o, output, 1, sticky stop-bit error flag.
REQ-015 The block SHALL have port word_cnt_o, output, ADDR_W+1, number of words written since load start.

Function
REQ-016 uart_rx SHALL pass through a 2-flop synchronizer before use; the synchronizer resets to 1.
REQ-017 The bit period SHALL be DIV = CLK_HZ/BAUD cycles, using integer division.
REQ-018 The RX FSM SHALL have states IDLE, START, DATA, and STOP.
- IDLE -> START on a synchronized falling edge, but only while load_en=1.
REQ-019 In START, the line SHALL be sampled at DIV/2 cycles.
- Line low -> DATA.
- Line high -> IDLE (glitch rejected; no error flagged).
REQ-020 In DATA, eight bits SHALL be sampled LSB-first, each DIV cycles after the previous sample.
REQ-021 In STOP, the line SHALL be sampled after DIV cycles.
- High -> the byte is accepted.
- Low -> frame_err_o is set, the byte is discarded, and the byte index is unchanged.
- Either way -> IDLE.
REQ-022 busy_o SHALL be 1 in every state except IDLE.
REQ-023 Accepted bytes SHALL be assembled little-endian: byte index 0 goes to wdata[7:0] and index 3 goes to wdata[31:24].
REQ-024 On acceptance of byte index 3, the following SHALL happen in the next cycle:
- we_o pulses exactly one cycle.
- waddr_o equals the current word counter.
- wdata_o holds the full word.
- The counter then increments and the byte index clears.
REQ-025 waddr_o and wdata_o SHALL remain stable until the next write.
REQ-026 When word_cnt_o reaches 2^ADDR_W, done_o SHALL be set; afterwards bytes are still received, but no write occurs and the address does not wrap.
REQ-027 A rising edge of load_en SHALL synchronously clear the following:
- Word counter.
- Byte index.
- done_o.
- frame_err_o.
REQ-028 A falling edge of load_en SHALL discard any partial word; a frame already in progress completes but is not stored.
REQ-029 cpu_hold_o SHALL equal load_en registered by one cycle.
REQ-030 A stop-bit acceptance and a load_en rising edge in the same cycle SHALL resolve with the clear taking priority, and the byte is discarded.

Reset
REQ-031 On rstn=0, the FSM SHALL go to IDLE.
REQ-032 On rstn=0, the following outputs SHALL be 0: we_o, waddr_o, wdata_o, busy_o, done_o, frame_err_o, word_cnt_o, cpu_hold_o.
REQ-033 On rstn=0, the byte index, bit counter, and baud counter SHALL clear.
REQ-034 A reset asserted mid-frame SHALL abort the frame with no write.
REQ-035 After reset release, the first complete frame SHALL be received normally.

Structure
REQ-036 A shared package SHALL hold the following:
- The RX FSM state enum.
- The 8N1 constants (DATA_BITS=8).
- The little-endian byte-lane mapping constants.
REQ-037 The byte receiver SHALL be one sub-module, uart_rx_byte, with outputs byte_valid (one cycle), byte_data, and frame_err; the word assembler and address counter reside in imem_loader.

Verification
REQ-038 The bench SHALL use CLK_HZ=1000000 and BAUD=100000 (DIV=10).
REQ-039 Bytes 0x93, 0x00, 0x50, 0x00 with load_en=1 -> exactly one we_o pulse, waddr_o=0, wdata_o=0x00500093, word_cnt_o=1.
REQ-040 uart_rx low for 3 cycles, then high -> no byte, frame_err_o=0, busy_o returns to 0 within 5 cycles.
REQ-041 A frame 0x13 with stop bit 0 -> frame_err_o=1, no write; the next four valid bytes write 1 word at address 0.
REQ-042 A stream of 65 words -> 64 we_o pulses at addresses 0..63, done_o=1 after the 64th, and the 65th produces no we_o.
REQ-043 load_en toggled 1->0->1 after 2 bytes, then 4 bytes 0x6F,0x00,0x00,0x00 -> write at waddr_o=0, wdata_o=0x0000006F.
REQ-044 rstn pulsed low during data bit 4 -> all outputs 0; the following 4-byte word is written at address 0 correctly.
